// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: fetch PC, IF/ID register and fetch/stall/flush counters
module if_stage #(
    parameter int              ADDR_LEN = 32,
    parameter int              DATA_LEN = 32,
    parameter logic [31:0]     RESET_PC = 32'h0000_0000,
    parameter logic [31:0]     NOP_INST = 32'h0000_0000,
    parameter int              CNT_LEN  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [ADDR_LEN-1:0] redirect_pc_i,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic [DATA_LEN-1:0] imem_rdata,
    output logic [ADDR_LEN-1:0] pc,
    output logic [DATA_LEN-1:0] inst,
    output logic [ADDR_LEN-1:0] if_id_pc,
    output logic [ADDR_LEN-1:0] if_id_pc4,
    output logic [DATA_LEN-1:0] if_id_inst,
    output logic                if_id_valid,
    output logic [CNT_LEN-1:0]  fetch_cnt,
    output logic [CNT_LEN-1:0]  stall_cnt,
    output logic [CNT_LEN-1:0]  flush_cnt
);

    logic do_redirect;
    logic do_stall;
    logic do_advance;

    // Redirect outranks stall: a taken branch squashes whatever the hazard unit was holding.
    assign do_redirect = redirect_i;
    assign do_stall    = stall_i & ~redirect_i;
    assign do_advance  = ~stall_i & ~redirect_i;

    assign imem_addr = pc;
    assign inst      = imem_rdata;
    assign if_id_pc4 = if_id_pc + ADDR_LEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC[ADDR_LEN-1:0];
        end else if (do_redirect) begin
            pc <= {redirect_pc_i[ADDR_LEN-1:2], 2'b00};
        end else if (do_advance) begin
            pc <= pc + ADDR_LEN'(4);
        end
    end

    // On redirect the IF/ID PC is left as is; only the instruction and valid bit are squashed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc    <= '0;
            if_id_inst  <= NOP_INST[DATA_LEN-1:0];
            if_id_valid <= 1'b0;
        end else if (do_redirect) begin
            if_id_inst  <= NOP_INST[DATA_LEN-1:0];
            if_id_valid <= 1'b0;
        end else if (do_advance) begin
            if_id_pc    <= pc;
            if_id_inst  <= imem_rdata;
            if_id_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (do_advance)  fetch_cnt <= fetch_cnt + CNT_LEN'(1);
            if (do_stall)    stall_cnt <= stall_cnt + CNT_LEN'(1);
            if (do_redirect) flush_cnt <= flush_cnt + CNT_LEN'(1);
        end
    end

endmodule
